// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encoding,
// default register-specifier width, performance-counter width and a
// saturating increment helper used by the counters.
package pipe_ctrl_pkg;

  // Default register-specifier width (8 architectural registers).
  localparam int REG_W_DEF = 3;

  // Width of the stall/flush performance counters.
  localparam int CNT_W = 16;

  // Fixed state codes kept as plain constants so older code that compares
  // against raw 2-bit values stays compatible with the enum below.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [1:0] {
    RUN    = ST_RUN,
    DRAIN  = ST_DRAIN,
    HALTED = ST_HALTED
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Ports: ID source specifiers + use flags, EX destination + load flag in;
//        lu_hazard out (ID instruction needs a value the EX load has not produced).
// Latency: purely combinational. No backpressure of its own.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  output logic             lu_hazard
);

  logic rs_match;
  logic rt_match;

  // Register 0 is deliberately not special-cased: a load targeting r0
  // still stalls a dependent reader.
  assign rs_match  = id_use_rs && (id_rs == ex_rd);
  assign rt_match  = id_use_rt && (id_rt == ex_rd);
  assign lu_hazard = ex_memread && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline hazard / halt controller.
// Latency: enables, flush and bubble are combinational (same-cycle effect);
//   state, drain counter and performance counters update on the rising edge.
// Backpressure: dmem_busy freezes every pipeline register and holds FSM state.
//
// Ports:
//   clk, rst (async, active-low)
//   id_rs/id_rt/id_use_rs/id_use_rt/id_halt : instruction in ID
//   ex_rd/ex_memread/ex_branch_taken       : instruction in EX
//   dmem_busy                              : data memory stall
//   pc_write/if_id_write/ex_mem_write/mem_wb_write : register load enables
//   if_id_flush/id_ex_bubble               : NOP / bubble insertion
//   halted, stall_cnt, flush_cnt           : status and perf counters
//
// Configuration: define PIPE_CTRL_PERF_EN to build the stall/flush counters;
// without it the counter ports are tied to zero.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W     = REG_W_DEF,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_halt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                DCNT_W    = $clog2(DRAIN_CYC) + 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

  state_e            state;
  state_e            state_nxt;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_nxt;
  logic              lu_hazard;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_use_rs  (id_use_rs),
    .id_use_rt  (id_use_rt),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .lu_hazard  (lu_hazard)
  );

  // Enables and next-state. Priority: freeze > branch > load-use > halt.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_nxt    = state;
    dcnt_nxt     = dcnt;

    if (dmem_busy) begin
      // Whole pipeline freezes; FSM and drain progress hold too.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (lu_hazard) begin
            // One bubble: next cycle the load has moved to MEM and the
            // comparator no longer matches.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_halt) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            state_nxt    = DRAIN;
            dcnt_nxt     = '0;
          end
        end

        DRAIN: begin
          if (ex_branch_taken) begin
            // An older branch resolved taken: the HALT was wrong-path.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_nxt    = RUN;
            dcnt_nxt     = '0;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (dcnt == DCNT_LAST) begin
              state_nxt = HALTED;
              dcnt_nxt  = '0;
            end else begin
              dcnt_nxt = dcnt + DCNT_W'(1);
            end
          end
        end

        HALTED: begin
          // Front end stays parked; downstream keeps shifting bubbles.
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end

        default: begin
          state_nxt = RUN;
          dcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign halted = (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Stalls are only counted while the core is live; a parked core is not stalling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_write && (state != HALTED)) begin
        stall_q <= sat_inc(stall_q);
      end
      if (if_id_flush) begin
        flush_q <= sat_inc(flush_q);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then randomized
// traffic, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int REG_W     = 3;
  localparam int DRAIN_CYC = 3;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             id_use_rs, id_use_rt, id_halt;
  logic             ex_memread, ex_branch_taken, dmem_busy;
  logic             pc_write, if_id_write, ex_mem_write, mem_wb_write;
  logic             if_id_flush, id_ex_bubble, halted;
  logic [15:0]      stall_cnt, flush_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: mode 0 = running, 1 = draining, 2 = stopped.
  int m_mode  = 0;
  int m_left  = 0;   // non-frozen drain cycles still owed
  int m_stall = 0;
  int m_flush = 0;

  pipe_ctrl #(.REG_W(REG_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .id_halt         (id_halt),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .dmem_busy       (dmem_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_halt = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, step past the rising edge.
  task automatic cycle(input string tag);
    bit lu;
    bit e_pc, e_ifid, e_down, e_fl, e_bub;
    @(negedge clk);
    lu = ex_memread && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    if (dmem_busy) begin
      e_pc = 0; e_ifid = 0; e_down = 0; e_fl = 0; e_bub = 0;
    end else begin
      e_down = 1;
      if (m_mode == 2 || (m_mode == 1 && !ex_branch_taken)) begin
        e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1;
      end else if (ex_branch_taken) begin
        e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1;
      end else if (lu || id_halt) begin
        e_pc = 0; e_ifid = 0; e_fl = 0; e_bub = 1;
      end else begin
        e_pc = 1; e_ifid = 1; e_fl = 0; e_bub = 0;
      end
    end
    check({tag, ".pc_write"},     16'(pc_write),     16'(e_pc));
    check({tag, ".if_id_write"},  16'(if_id_write),  16'(e_ifid));
    check({tag, ".ex_mem_write"}, 16'(ex_mem_write), 16'(e_down));
    check({tag, ".mem_wb_write"}, 16'(mem_wb_write), 16'(e_down));
    check({tag, ".if_id_flush"},  16'(if_id_flush),  16'(e_fl));
    check({tag, ".id_ex_bubble"}, 16'(id_ex_bubble), 16'(e_bub));
    check({tag, ".halted"},       16'(halted),       16'(m_mode == 2));
    check({tag, ".stall_cnt"},    stall_cnt,         16'(m_stall));
    check({tag, ".flush_cnt"},    flush_cnt,         16'(m_flush));

    if (PERF && !e_pc && m_mode != 2 && m_stall < 65535) m_stall++;
    if (PERF && e_fl && m_flush < 65535) m_flush++;
    if (!dmem_busy) begin
      if (m_mode == 0 && !ex_branch_taken && !lu && id_halt) begin
        m_mode = 1;
        m_left = DRAIN_CYC;
      end else if (m_mode == 1) begin
        if (ex_branch_taken) begin
          m_mode = 0;
        end else begin
          m_left--;
          if (m_left == 0) m_mode = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from any clock edge and checks it acts immediately.
  task automatic apply_reset(input string tag);
    idle_inputs();
    rst = 1'b0;
    #2;
    check({tag, ".rst_halted"}, 16'(halted),    16'd0);
    check({tag, ".rst_stall"},  stall_cnt,      16'd0);
    check({tag, ".rst_flush"},  flush_cnt,      16'd0);
    check({tag, ".rst_pc"},     16'(pc_write),  16'd1);
    check({tag, ".rst_bubble"}, 16'(id_ex_bubble), 16'd0);
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int n_sat;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    apply_reset("por");
    cycle("idle");

    // Load-use on rs: one stall cycle, counter shows it next cycle.
    ex_memread = 1; ex_rd = 3; id_use_rs = 1; id_rs = 3;
    cycle("lu");
    idle_inputs();
    cycle("lu_after");

    // Load-use on rt with r0 (not exempt).
    ex_memread = 1; ex_rd = 0; id_use_rt = 1; id_rt = 0; id_rs = 0;
    cycle("lu_r0");
    idle_inputs();
    cycle("lu_r0_after");

    // Branch beats load-use.
    apply_reset("r030");
    ex_memread = 1; ex_rd = 3; id_use_rs = 1; id_rs = 3; ex_branch_taken = 1;
    cycle("br_lu");
    idle_inputs();
    cycle("br_lu_after");

    // Halt with one frozen DRAIN cycle: halted after 1+3+1 cycles.
    apply_reset("r031");
    id_halt = 1;
    cycle("halt_run");
    idle_inputs();
    cycle("drain0");
    dmem_busy = 1;
    cycle("drain_freeze");
    dmem_busy = 0;
    cycle("drain1");
    cycle("drain2");
    check("halt_at_5", 16'(halted), 16'd1);
    ex_branch_taken = 1; id_halt = 1; ex_memread = 1; id_use_rs = 1;
    cycle("halted_ignore");
    idle_inputs();
    dmem_busy = 1;
    cycle("halted_freeze");
    idle_inputs();
    cycle("halted_hold");

    // Wrong-path halt cancelled by a branch in DRAIN.
    apply_reset("r032");
    id_halt = 1;
    cycle("halt2");
    idle_inputs();
    ex_branch_taken = 1;
    cycle("drain_branch");
    idle_inputs();
    for (int i = 0; i < 5; i++) cycle("after_cancel");
    check("cancel_not_halted", 16'(halted), 16'd0);

    // Freeze beats branch for 4 cycles, then the flush fires.
    apply_reset("r033");
    dmem_busy = 1; ex_branch_taken = 1;
    for (int i = 0; i < 4; i++) cycle("busy_branch");
    dmem_busy = 0;
    cycle("branch_release");
    idle_inputs();
    cycle("branch_release_after");

    // Randomized traffic with periodic resets.
    apply_reset("rand");
    for (int i = 0; i < 600; i++) begin
      if (i % 90 == 89) apply_reset("rand_rst");
      id_rs           = REG_W'($urandom_range(0, 7));
      id_rt           = REG_W'($urandom_range(0, 7));
      ex_rd           = REG_W'($urandom_range(0, 7));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      dmem_busy       = ($urandom_range(0, 5) == 0);
      id_halt         = ($urandom_range(0, 11) == 0);
      cycle("rand");
    end

    // Counter saturation, then asynchronous reset clears everything.
    apply_reset("r034");
    ex_branch_taken = 1;
    cycle("sat_flush0");
    cycle("sat_flush1");
    idle_inputs();
    ex_memread = 1; ex_rd = 5; id_use_rt = 1; id_rt = 5;
    n_sat = PERF ? 65540 : 100;
    repeat (n_sat) @(posedge clk);
    #1;
    check("stall_sat", stall_cnt, PERF ? 16'hFFFF : 16'h0000);
    check("flush_kept", flush_cnt, PERF ? 16'd2 : 16'd0);
    apply_reset("sat_rst");
    cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
